// File: rtl/snoopy_pkg.sv
// Shared state encodings and default tuning for Snoopy's horizontal motion control.
package snoopy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    PAUSED = 2'b11
  } move_state_t;

  localparam int X_W              = 8;
  localparam int DEF_SLOW_PERIOD  = 4;
  localparam int DEF_FAST_PERIOD  = 1;
  localparam int DEF_ACCEL_FRAMES = 16;
  localparam int DEF_MAX_X        = 160;
  localparam int DEF_CNT_W        = 5;

  function automatic logic is_moving(input move_state_t s);
    return (s == LEFT) || (s == RIGHT);
  endfunction

endpackage

// File: rtl/snoopy_req_edge.sv
// Registers the merged {left, right} request pair and flags a fresh press on each bit.
module snoopy_req_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] req_q,
  output logic [1:0] rise
);

  logic [1:0] req_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q    <= 2'b00;
      req_prev <= 2'b00;
    end else begin
      req_q    <= req;
      req_prev <= req_q;
    end
  end

  assign rise = req_q & ~req_prev;

endmodule

// File: rtl/snoopy_motion_scheduler.sv
// Arbitrates left/right requests and paces single-cycle step pulses to the frame tick,
// switching to a faster step period after a sustained hold in one direction.
module snoopy_motion_scheduler
  import snoopy_pkg::*;
#(
  parameter int SLOW_PERIOD  = DEF_SLOW_PERIOD,
  parameter int FAST_PERIOD  = DEF_FAST_PERIOD,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int MAX_X        = DEF_MAX_X,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           kb_left,
  input  logic           kb_right,
  input  logic           pause,
  input  logic [X_W-1:0] pos_x,
  output logic           step_left,
  output logic           step_right,
  output logic [1:0]     move_state,
  output logic           fast
);

  logic [1:0]       req_q;
  logic [1:0]       rise;
  logic             req_l, req_r, rise_l, rise_r;
  move_state_t      state, next_state;
  logic [CNT_W-1:0] frame_cnt, hold_cnt, hold_next, period_m1;

  snoopy_req_edge u_req_edge (
    .clock (clock),
    .reset (reset),
    .req   ({btn_left | kb_left, btn_right | kb_right}),
    .req_q (req_q),
    .rise  (rise)
  );

  // Arbitration works entirely on the registered requests so press edges and levels agree.
  assign req_l  = req_q[1];
  assign req_r  = req_q[0];
  assign rise_l = rise[1];
  assign rise_r = rise[0];

  always_comb begin
    next_state = state;
    if (pause) begin
      next_state = PAUSED;
    end else begin
      case (state)
        IDLE: begin
          if (req_l)      next_state = LEFT;
          else if (req_r) next_state = RIGHT;
        end
        LEFT: begin
          if (rise_r)      next_state = RIGHT;
          else if (!req_l) next_state = req_r ? RIGHT : IDLE;
        end
        RIGHT: begin
          if (rise_l)      next_state = LEFT;
          else if (!req_r) next_state = req_l ? LEFT : IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_next = (hold_cnt == CNT_W'(ACCEL_FRAMES)) ? hold_cnt : hold_cnt + CNT_W'(1);
    period_m1 = fast ? CNT_W'(FAST_PERIOD - 1) : CNT_W'(SLOW_PERIOD - 1);
  end

  // Any state change restarts pacing, so a tick coinciding with a transition never steps.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      fast       <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
    end else begin
      state      <= next_state;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      if (!is_moving(next_state) || (next_state != state)) begin
        frame_cnt <= '0;
        hold_cnt  <= '0;
        fast      <= 1'b0;
      end else if (frame_tick) begin
        if (frame_cnt == '0) begin
          frame_cnt  <= period_m1;
          step_left  <= (state == LEFT) && (pos_x != '0);
          step_right <= (state == RIGHT) && (pos_x < X_W'(MAX_X));
        end else begin
          frame_cnt <= frame_cnt - CNT_W'(1);
        end
        hold_cnt <= hold_next;
        fast     <= (hold_next == CNT_W'(ACCEL_FRAMES));
      end
    end
  end

  assign move_state = state;

endmodule
